// File: rtl/aes_ptext_pkg.sv
// Shared definitions for the AES plaintext generator: source-mode encoding,
// FSM state encoding and the xorshift128 step used by the PRNG.
package aes_ptext_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_FIXED = 2'd0;
    localparam logic [MODE_W-1:0] MODE_INC   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_RAND  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_TVLA  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GO    = 2'd2
    } state_t;

    // xorshift128 locks up on an all-zero state, so a zero seed is swapped for this
    localparam logic [127:0] PRNG_ZERO_SEED = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam int           PRNG_STEPS     = 4;

    // State packing is {w, z, y, x}, w in the top word
    function automatic logic [127:0] xorshift_step(input logic [127:0] s);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] w;
        logic [31:0] t;
        x = s[31:0];
        y = s[63:32];
        z = s[95:64];
        w = s[127:96];
        t = x ^ (x << 11);
        return {w ^ (w >> 19) ^ t ^ (t >> 8), w, z, y};
    endfunction

endpackage

// File: rtl/aes_ptext_gen_if.sv
// Control, status and FIFO-write bundle between a batch controller (master)
// and the plaintext generator (slave).
interface aes_ptext_gen_if
    import aes_ptext_pkg::*;
#(
    parameter int pCOUNT_W = 10
);
    logic                start_i;
    logic                abort_i;
    logic [MODE_W-1:0]   mode_i;
    logic [pCOUNT_W-1:0] count_i;
    logic [127:0]        seed_i;
    logic [127:0]        fixed_i;
    logic                fifo_full_i;

    logic                wr_o;
    logic [127:0]        data_o;
    logic                go_o;
    logic                group_o;
    logic                busy_o;
    logic                done_o;
    logic                clamp_err_o;

    modport master (
        output start_i, abort_i, mode_i, count_i, seed_i, fixed_i, fifo_full_i,
        input  wr_o, data_o, go_o, group_o, busy_o, done_o, clamp_err_o
    );

    modport slave (
        input  start_i, abort_i, mode_i, count_i, seed_i, fixed_i, fifo_full_i,
        output wr_o, data_o, go_o, group_o, busy_o, done_o, clamp_err_o
    );
endinterface

// File: rtl/aes_ptext_prng.sv
// Combinational four-step xorshift128 advance: one call yields one PRNG output.
module aes_ptext_prng
    import aes_ptext_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    logic [127:0] stage [0:PRNG_STEPS];

    assign stage[0] = state_i;

    generate
        for (genvar gi = 0; gi < PRNG_STEPS; gi++) begin : g_step
            assign stage[gi+1] = xorshift_step(stage[gi]);
        end
    endgenerate

    assign state_o = stage[PRNG_STEPS];
endmodule

// File: rtl/aes_ptext_gen.sv
// Plaintext batch generator feeding the AES input FIFO, running in the FIFO write clock.
// Define AES_PTEXT_GEN_TVLA_EN to enable the TVLA fixed/random alternating mode.
module aes_ptext_gen
    import aes_ptext_pkg::*;
#(
    parameter int pFIFO_DEPTH = 512,
    parameter int pCOUNT_W    = 10
) (
    input  logic           usb_clk,
    input  logic           reset_n,
    aes_ptext_gen_if.slave bus
);
`ifdef AES_PTEXT_GEN_TVLA_EN
    localparam bit TVLA_EN = 1'b1;
`else
    localparam bit TVLA_EN = 1'b0;
`endif

    localparam logic [pCOUNT_W-1:0] DEPTH_C = pCOUNT_W'(pFIFO_DEPTH);
    localparam logic [pCOUNT_W-1:0] ONE_C   = pCOUNT_W'(1);

    state_t              state_reg,   state_next;
    logic [MODE_W-1:0]   mode_reg,    mode_next;
    logic [127:0]        fixed_reg,   fixed_next;
    logic [pCOUNT_W-1:0] count_reg,   count_next;
    logic [pCOUNT_W-1:0] blk_cnt_reg, blk_cnt_next;
    logic [127:0]        data_reg,    data_next;
    logic [127:0]        prng_reg,    prng_next;
    logic                group_reg,   group_next;
    logic                clamp_reg,   clamp_next;
    logic                go_reg,      go_next;
    logic                done_reg,    done_next;
    logic                busy_reg;

    logic                wr;
    logic                last_wr;
    logic                count_clamped;
    logic [pCOUNT_W-1:0] count_eff;
    logic [MODE_W-1:0]   mode_eff;
    logic [127:0]        seed_eff;
    logic [127:0]        prng_in;
    logic [127:0]        prng_out;

    assign wr            = (state_reg == ST_WRITE) && !bus.fifo_full_i;
    assign last_wr       = wr && (blk_cnt_reg == (count_reg - ONE_C));
    assign count_clamped = (bus.count_i > DEPTH_C);
    assign count_eff     = count_clamped ? DEPTH_C : bus.count_i;
    assign seed_eff      = (bus.seed_i == '0) ? PRNG_ZERO_SEED : bus.seed_i;
    // Without the TVLA build option, mode 3 collapses onto plain random mode
    assign mode_eff      = (bus.mode_i == MODE_TVLA && !TVLA_EN) ? MODE_RAND : bus.mode_i;

    // Single PRNG instance: seeds from the input at start, advances from state afterwards
    assign prng_in = (state_reg == ST_IDLE) ? seed_eff : prng_reg;

    aes_ptext_prng u_prng (
        .state_i (prng_in),
        .state_o (prng_out)
    );

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        fixed_next   = fixed_reg;
        count_next   = count_reg;
        blk_cnt_next = blk_cnt_reg;
        data_next    = data_reg;
        prng_next    = prng_reg;
        group_next   = group_reg;
        clamp_next   = clamp_reg;
        go_next      = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    mode_next    = mode_eff;
                    fixed_next   = bus.fixed_i;
                    count_next   = count_eff;
                    blk_cnt_next = '0;
                    clamp_next   = count_clamped;
                    group_next   = (mode_eff == MODE_TVLA);
                    // TVLA opens with a fixed block, so the seed is kept unconsumed
                    prng_next    = (mode_eff == MODE_TVLA) ? seed_eff : prng_out;
                    case (mode_eff)
                        MODE_INC:  data_next = bus.seed_i;
                        MODE_RAND: data_next = prng_out;
                        default:   data_next = bus.fixed_i;
                    endcase
                    if (count_eff == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                if (wr) begin
                    blk_cnt_next = blk_cnt_reg + ONE_C;
                    case (mode_reg)
                        MODE_INC: data_next = data_reg + 128'd1;
                        MODE_RAND: begin
                            data_next = prng_out;
                            prng_next = prng_out;
                        end
                        MODE_TVLA: begin
                            group_next = !group_reg;
                            if (group_reg) begin
                                data_next = prng_out;
                                prng_next = prng_out;
                            end else begin
                                data_next = fixed_reg;
                            end
                        end
                        default: data_next = fixed_reg;
                    endcase
                end
                if (bus.abort_i) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (last_wr) begin
                    state_next = ST_GO;
                    go_next    = 1'b1;
                    done_next  = 1'b1;
                end
            end

            ST_GO:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            mode_reg    <= MODE_FIXED;
            fixed_reg   <= '0;
            count_reg   <= '0;
            blk_cnt_reg <= '0;
            data_reg    <= '0;
            prng_reg    <= '0;
            group_reg   <= 1'b0;
            clamp_reg   <= 1'b0;
            go_reg      <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            fixed_reg   <= fixed_next;
            count_reg   <= count_next;
            blk_cnt_reg <= blk_cnt_next;
            data_reg    <= data_next;
            prng_reg    <= prng_next;
            group_reg   <= group_next;
            clamp_reg   <= clamp_next;
            go_reg      <= go_next;
            done_reg    <= done_next;
            busy_reg    <= (state_next != ST_IDLE);
        end
    end

    assign bus.wr_o        = wr;
    assign bus.data_o      = data_reg;
    assign bus.go_o        = go_reg;
    assign bus.group_o     = TVLA_EN ? group_reg : 1'b0;
    assign bus.busy_o      = busy_reg;
    assign bus.done_o      = done_reg;
    assign bus.clamp_err_o = clamp_reg;
endmodule

// File: tb/tb_aes_ptext_gen.sv
// Directed bench for aes_ptext_gen: fixed, increment, random and TVLA batches,
// FIFO stalls, clamping, abort, ignored restarts and reset behaviour.
module tb_aes_ptext_gen;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    aes_ptext_gen_if #(.pCOUNT_W(10)) bus ();

    aes_ptext_gen #(.pFIFO_DEPTH(512), .pCOUNT_W(10)) dut (
        .usb_clk (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    int           n_wr;
    int           go_n;
    int           go_cyc;
    int           done_n;
    int           done_cyc;
    logic [127:0] wr_data [600];
    logic         wr_grp  [600];
    logic [127:0] data_at [600];
    logic         busy_at [600];

    localparam logic [127:0] ZSEED = 128'h0123456789ABCDEFFEDCBA9876543210;

    // Reference xorshift128: four steps per output, w in the top word
    function automatic logic [127:0] ref_prng4(input logic [127:0] s);
        logic [31:0] x, y, z, w, t;
        {w, z, y, x} = s;
        for (int i = 0; i < 4; i++) begin
            t = x ^ (x << 11);
            x = y;
            y = z;
            z = w;
            w = w ^ (w >> 19) ^ t ^ (t >> 8);
        end
        return {w, z, y, x};
    endfunction

    // Runs ncycles cycles from posedge+1; start_i in cycle 0, observations at negedge
    task automatic run_batch(input logic [1:0] mode, input logic [9:0] count,
                             input logic [127:0] seed, input logic [127:0] fixed,
                             input int stall_start, input int stall_len,
                             input int abort_cyc, input int restart_cyc, input int ncycles);
        n_wr = 0; go_n = 0; go_cyc = -1; done_n = 0; done_cyc = -1;
        for (int c = 0; c < ncycles; c++) begin
            bus.start_i = (c == 0) || (c == restart_cyc);
            if (c == 0) begin
                bus.mode_i = mode; bus.count_i = count; bus.seed_i = seed; bus.fixed_i = fixed;
            end else begin
                bus.mode_i = ~mode; bus.count_i = count ^ 10'h2AA; bus.seed_i = ~seed; bus.fixed_i = ~fixed;
            end
            bus.abort_i     = (c == abort_cyc);
            bus.fifo_full_i = (c >= stall_start) && (c < stall_start + stall_len);
            @(negedge clk);
            busy_at[c] = bus.busy_o;
            data_at[c] = bus.data_o;
            if (bus.wr_o === 1'b1) begin
                wr_data[n_wr] = bus.data_o;
                wr_grp[n_wr]  = bus.group_o;
                n_wr++;
            end
            if (bus.go_o === 1'b1) begin go_n++; go_cyc = c; end
            if (bus.done_o === 1'b1) begin done_n++; done_cyc = c; end
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.fifo_full_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.start_i = 0; bus.abort_i = 0; bus.mode_i = 0; bus.count_i = 0;
        bus.seed_i = 0; bus.fixed_i = 0; bus.fifo_full_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b expected 0", bus.wr_o); end
        checks++; if (bus.go_o !== 1'b0) begin errors++; $display("FAIL reset_go got %b expected 0", bus.go_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy_o); end
        checks++; if (bus.clamp_err_o !== 1'b0) begin errors++; $display("FAIL reset_clamp got %b expected 0", bus.clamp_err_o); end
        checks++; if (bus.group_o !== 1'b0) begin errors++; $display("FAIL reset_group got %b expected 0", bus.group_o); end
        checks++; if (bus.data_o !== 128'd0) begin errors++; $display("FAIL reset_data got %h expected 0", bus.data_o); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed;
        run_batch(2'd0, 10'd3, 128'd0, {16{8'hAA}}, -1, 0, -1, -1, 6);
        checks++; if (n_wr != 3) begin errors++; $display("FAIL fixed_nwr got %0d expected 3", n_wr); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (wr_data[k] !== {16{8'hAA}}) begin errors++; $display("FAIL fixed_data%0d got %h expected %h", k, wr_data[k], {16{8'hAA}}); end
        end
        checks++; if (go_n != 1 || go_cyc != 4) begin errors++; $display("FAIL fixed_go got n=%0d cyc=%0d expected n=1 cyc=4", go_n, go_cyc); end
        checks++; if (done_n != 1 || done_cyc != 4) begin errors++; $display("FAIL fixed_done got n=%0d cyc=%0d expected n=1 cyc=4", done_n, done_cyc); end
        checks++; if (busy_at[1] !== 1'b1 || busy_at[4] !== 1'b1 || busy_at[5] !== 1'b0) begin
            errors++; $display("FAIL fixed_busy got %b%b%b expected 110", busy_at[1], busy_at[4], busy_at[5]); end
    endtask

    task automatic test_increment_wrap;
        logic [127:0] exp [3];
        exp[0] = {{15{8'hFF}}, 8'hFE};
        exp[1] = {16{8'hFF}};
        exp[2] = 128'd0;
        run_batch(2'd1, 10'd3, {{15{8'hFF}}, 8'hFE}, 128'd5, -1, 0, -1, -1, 6);
        checks++; if (n_wr != 3) begin errors++; $display("FAIL inc_nwr got %0d expected 3", n_wr); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (wr_data[k] !== exp[k]) begin errors++; $display("FAIL inc_data%0d got %h expected %h", k, wr_data[k], exp[k]); end
        end
    endtask

    task automatic test_stall;
        logic [127:0] s;
        s = 128'h1000;
        run_batch(2'd1, 10'd4, s, 128'd0, 3, 5, -1, -1, 12);
        checks++; if (n_wr != 4) begin errors++; $display("FAIL stall_nwr got %0d expected 4", n_wr); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (wr_data[k] !== s + 128'(k)) begin errors++; $display("FAIL stall_data%0d got %h expected %h", k, wr_data[k], s + 128'(k)); end
        end
        for (int c = 3; c < 8; c++) begin
            checks++; if (data_at[c] !== s + 128'd2) begin errors++; $display("FAIL stall_hold%0d got %h expected %h", c, data_at[c], s + 128'd2); end
        end
        checks++; if (go_cyc != 10) begin errors++; $display("FAIL stall_go got cyc=%0d expected cyc=10", go_cyc); end
    endtask

    task automatic test_random_zero_seed;
        logic [127:0] p;
        run_batch(2'd2, 10'd3, 128'd0, 128'd0, -1, 0, -1, -1, 6);
        checks++; if (n_wr != 3) begin errors++; $display("FAIL rand_nwr got %0d expected 3", n_wr); end
        p = ZSEED;
        for (int k = 0; k < 3; k++) begin
            p = ref_prng4(p);
            checks++; if (wr_data[k] !== p) begin errors++; $display("FAIL rand_data%0d got %h expected %h", k, wr_data[k], p); end
        end
        checks++; if (go_cyc != 4) begin errors++; $display("FAIL rand_go got cyc=%0d expected cyc=4", go_cyc); end
    endtask

    task automatic test_tvla;
        logic [127:0] s, f, p, e;
        logic         g;
        s = 128'h00000001_00000002_00000003_00000004;
        f = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;
        run_batch(2'd3, 10'd4, s, f, -1, 0, -1, -1, 7);
        checks++; if (n_wr != 4) begin errors++; $display("FAIL tvla_nwr got %0d expected 4", n_wr); end
        p = s;
        for (int k = 0; k < 4; k++) begin
`ifdef AES_PTEXT_GEN_TVLA_EN
            if (k % 2 == 0) begin e = f; g = 1'b1; end
            else begin p = ref_prng4(p); e = p; g = 1'b0; end
`else
            p = ref_prng4(p); e = p; g = 1'b0;
`endif
            checks++; if (wr_data[k] !== e || wr_grp[k] !== g) begin
                errors++; $display("FAIL tvla_blk%0d got %h/%b expected %h/%b", k, wr_data[k], wr_grp[k], e, g); end
        end
        checks++; if (go_cyc != 5) begin errors++; $display("FAIL tvla_go got cyc=%0d expected cyc=5", go_cyc); end
    endtask

    task automatic test_clamp;
        run_batch(2'd0, 10'd600, 128'd0, 128'h77, -1, 0, -1, -1, 516);
        checks++; if (n_wr != 512) begin errors++; $display("FAIL clamp_nwr got %0d expected 512", n_wr); end
        checks++; if (go_cyc != 513) begin errors++; $display("FAIL clamp_go got cyc=%0d expected cyc=513", go_cyc); end
        checks++; if (bus.clamp_err_o !== 1'b1) begin errors++; $display("FAIL clamp_set got %b expected 1", bus.clamp_err_o); end
        run_batch(2'd0, 10'd0, 128'd0, 128'h77, -1, 0, -1, -1, 3);
        checks++; if (n_wr != 0 || go_n != 0) begin errors++; $display("FAIL zero_wrgo got wr=%0d go=%0d expected 0/0", n_wr, go_n); end
        checks++; if (done_n != 1 || done_cyc != 1) begin errors++; $display("FAIL zero_done got n=%0d cyc=%0d expected n=1 cyc=1", done_n, done_cyc); end
        checks++; if (busy_at[1] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b expected 0", busy_at[1]); end
        checks++; if (bus.clamp_err_o !== 1'b0) begin errors++; $display("FAIL clamp_clear got %b expected 0", bus.clamp_err_o); end
    endtask

    task automatic test_abort;
        run_batch(2'd0, 10'd5, 128'd0, 128'h99, -1, 0, 2, -1, 8);
        checks++; if (n_wr != 2) begin errors++; $display("FAIL abort_nwr got %0d expected 2", n_wr); end
        checks++; if (go_n != 0) begin errors++; $display("FAIL abort_go got %0d expected 0", go_n); end
        checks++; if (done_n != 1 || done_cyc != 3) begin errors++; $display("FAIL abort_done got n=%0d cyc=%0d expected n=1 cyc=3", done_n, done_cyc); end
        checks++; if (busy_at[3] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy_at[3]); end
    endtask

    task automatic test_back_to_back;
        run_batch(2'd1, 10'd3, 128'd100, 128'd0, -1, 0, -1, 2, 5);
        checks++; if (n_wr != 3 || go_cyc != 4) begin errors++; $display("FAIL b2b_first got wr=%0d go=%0d expected 3/4", n_wr, go_cyc); end
        checks++; if (wr_data[2] !== 128'd102) begin errors++; $display("FAIL b2b_latch got %h expected %h", wr_data[2], 128'd102); end
        run_batch(2'd0, 10'd2, 128'd0, 128'h3C, -1, 0, -1, -1, 5);
        checks++; if (n_wr != 2 || go_cyc != 3) begin errors++; $display("FAIL b2b_second got wr=%0d go=%0d expected 2/3", n_wr, go_cyc); end
        checks++; if (wr_data[1] !== 128'h3C) begin errors++; $display("FAIL b2b_data got %h expected %h", wr_data[1], 128'h3C); end
    endtask

    task automatic test_reset_mid_batch;
        int seen;
        bus.start_i = 1'b1; bus.mode_i = 2'd0; bus.count_i = 10'd5; bus.fixed_i = 128'h55;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr_o !== 1'b1) begin errors++; $display("FAIL mid_pre_wr got %b expected 1", bus.wr_o); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.wr_o !== 1'b0 || bus.data_o !== 128'd0) begin
            errors++; $display("FAIL mid_async got busy=%b wr=%b data=%h expected 0/0/0", bus.busy_o, bus.wr_o, bus.data_o); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.wr_o !== 1'b0 || bus.busy_o !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_nowrite got %0d active cycles expected 0", seen); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_fixed;
        test_increment_wrap;
        test_stall;
        test_random_zero_seed;
        test_tvla;
        test_clamp;
        test_abort;
        test_back_to_back;
        test_reset_mid_batch;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_ptext_gen.md
AES_PTEXT_GEN -- requirements
Module: aes_ptext_gen

Interface
REQ-001 Parameter pFIFO_DEPTH, default 512: input-FIFO depth; upper bound on blocks per batch.
REQ-002 Parameter pCOUNT_W, default 10: width of the block-count input; SHALL hold pFIFO_DEPTH.
REQ-003 usb_clk  in  1  sole clock; the block SHALL run in the input-FIFO write domain.
REQ-004 reset_n  in  1  reset; asynchronous, active-low.
REQ-005 start_i  in  1  one-cycle pulse that begins a batch.
REQ-006 abort_i  in  1  one-cycle pulse that terminates the current batch.
REQ-007 mode_i  in  2  block source: 0 fixed, 1 increment, 2 random, 3 TVLA fixed/random alternate.
REQ-008 count_i  in  pCOUNT_W  number of blocks in the batch.
REQ-009 seed_i  in  128  start value for increment mode, and PRNG seed.
REQ-010 fixed_i  in  128  fixed plaintext.
REQ-011 fifo_full_i  in  1  input-FIFO full flag (write side).
REQ-012 wr_o  out  1  FIFO write strobe, driving write_data.
REQ-013 data_o  out  128  plaintext block, driving data_i.
REQ-014 go_o  out  1  one-cycle encrypt request; the integrator SHALL synchronise it to clk.
REQ-015 group_o  out  1  TVLA group of the block currently on data_o: 1 = fixed, 0 = random.
REQ-016 busy_o, done_o, clamp_err_o  out  1 each  batch active; one-cycle end pulse; sticky clamp flag.

Function
REQ-017 FSM states: IDLE, WRITE, GO. Transitions:
  - IDLE -> WRITE on start_i with count_i != 0.
  - WRITE -> GO in the cycle the last block is written.
  - GO -> IDLE after exactly one cycle.
REQ-018 start_i with count_i == 0 SHALL stay in IDLE and pulse done_o the next cycle, with no wr_o and no go_o.
REQ-019 start_i SHALL latch mode_i, seed_i, fixed_i and count_i; changes to these inputs during a batch SHALL have no effect.
REQ-020 count_i > pFIFO_DEPTH SHALL be clamped to pFIFO_DEPTH and SHALL set clamp_err_o.
REQ-021 clamp_err_o SHALL clear on the next start_i that is not clamped.
REQ-022 wr_o SHALL be (state == WRITE) && !fifo_full_i, combinationally; it SHALL be the only combinational output.
REQ-023 data_o SHALL be registered, valid from the cycle after start_i, and SHALL advance to the next block on the edge that ends a wr_o cycle.
REQ-024 A write SHALL occur only when wr_o is high; while fifo_full_i is high the block counter and data_o SHALL hold.
REQ-025 Block k (k = 0 .. N-1) content:
  - mode 0: fixed_i.
  - mode 1: seed_i + k modulo 2^128.
  - mode 2: PRNG output k.
  - mode 3: even k gives fixed_i with group_o = 1; odd k gives the next PRNG output with group_o = 0.
REQ-026 PRNG: 128-bit xorshift128 state {x,y,z,w}, 32-bit words, w most significant. One step is:
  - t = x ^ (x << 11); x = y; y = z; z = w;
  - w = w ^ (w >> 19) ^ t ^ (t >> 8).
REQ-027 Each PRNG output SHALL be the state after 4 steps; the state SHALL advance only when a random block is consumed.
REQ-028 A seed of all zeros SHALL be replaced by 128'h0123456789ABCDEFFEDCBA9876543210.
REQ-029 go_o and done_o SHALL pulse in the GO cycle; the first write is at cycle 1 after start_i, so the minimum latency from start_i to go_o is N+1 cycles.
REQ-030 start_i while busy_o is high SHALL be ignored.
REQ-031 abort_i SHALL return the FSM to IDLE on the next edge, with no go_o and with done_o pulsed; abort_i SHALL take priority over a simultaneous last write.
REQ-032 busy_o SHALL be high in WRITE and GO.

Reset
REQ-033 On reset_n low, asynchronously:
  - state = IDLE.
  - wr_o, go_o, done_o, busy_o, clamp_err_o, group_o = 0.
  - data_o = 0; PRNG state = 0; block counter = 0.
REQ-034 Reset deasserted mid-batch SHALL produce no further writes until a new start_i.

Configuration
REQ-035 With macro AES_PTEXT_GEN_TVLA_EN defined, mode 3 SHALL behave as in REQ-025.
REQ-036 Without AES_PTEXT_GEN_TVLA_EN, mode 3 SHALL behave as mode 2, and group_o SHALL be tied to 0.

Structure
REQ-037 Shared package aes_ptext_pkg SHALL hold:
  - the mode encoding constants;
  - the FSM state encoding;
  - the PRNG zero-seed replacement constant.
REQ-038 Sub-module aes_ptext_prng SHALL be combinational: 128-bit state in, 4-step state out.

Verification
REQ-039 Mode 0, count 3, fixed_i = 128'hAA..AA, fifo_full_i = 0 -> wr_o high in cycles 1-3 with data_o = AA..AA each time, go_o and done_o in cycle 4.
REQ-040 Mode 1, seed_i = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, count 3 -> data_o = ...FFFE, ...FFFF, 0 (128-bit wrap).
REQ-041 Mode 1, count 4, fifo_full_i high for 5 cycles after the 2nd write -> exactly 4 writes, data_o held during the stall, go_o at cycle 10.
REQ-042 Mode 3 with the TVLA macro, count 4 -> group_o sequence 1,0,1,0, even blocks equal fixed_i, odd blocks match a reference xorshift model.
REQ-043 count_i = 600 -> exactly 512 writes, clamp_err_o = 1; a following start_i with count 0 -> done_o only, clamp_err_o = 0.
REQ-044 abort_i on the same edge as the 2nd of 5 writes -> 2 writes total, no go_o, done_o pulsed, busy_o = 0 the next cycle.
